// File: rtl/avalon_st_if.sv
// avalon_st_if: Avalon-ST bundle with valid/rdy handshake, packet framing, empty and data
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 8
);
  localparam int EW = DATA_WIDTH_IN_BYTES > 1 ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  logic valid;
  logic rdy;
  logic sop;
  logic eop;
  logic [EW-1:0] empty;
  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  modport master(output valid, sop, eop, empty, data, input rdy);
  modport slave(input valid, sop, eop, empty, data, output rdy);
endinterface

// File: rtl/avalon_packet_limiter.sv
// avalon_packet_limiter: bounds Avalon-ST packets to MAX_WORDS beats, truncating oversize packets and counting dropped beats
module avalon_packet_limiter #(
  parameter int DATA_WIDTH_IN_BYTES = 8,
  parameter int MAX_WORDS = 64
) (
  input logic clk,
  input logic rst,
  avalon_st_if.slave msg_in,
  avalon_st_if.master msg_out,
  output logic packet_truncated,
  output logic [15:0] dropped_words
);
  localparam int EW = DATA_WIDTH_IN_BYTES > 1 ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam int CW = $clog2(MAX_WORDS + 1);
  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} state_t;
  state_t state;
  logic [CW-1:0] word_cnt;
  logic acc;
  logic trunc;
  logic fwd;
  logic [15:0] dw_sat;
  assign msg_in.rdy = (state == DROP) | ~msg_out.valid | msg_out.rdy;
  assign acc = msg_in.valid & msg_in.rdy;
  assign trunc = (state == IN_PKT) & ~msg_in.eop & ((word_cnt + CW'(1)) == CW'(MAX_WORDS));
  assign fwd = acc & ((state == IN_PKT) | ((state == IDLE) & msg_in.sop));
  assign dw_sat = dropped_words + 16'(dropped_words != 16'hFFFF);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      word_cnt <= '0;
      packet_truncated <= 1'b0;
      dropped_words <= '0;
      msg_out.valid <= 1'b0;
      msg_out.sop <= 1'b0;
      msg_out.eop <= 1'b0;
      msg_out.empty <= '0;
      msg_out.data <= '0;
    end else begin
      packet_truncated <= acc & trunc;
      if (fwd) begin
        msg_out.valid <= 1'b1;
        msg_out.sop <= state == IDLE;
        msg_out.eop <= msg_in.eop | trunc;
        msg_out.empty <= msg_in.eop ? msg_in.empty : EW'(0);
        msg_out.data <= msg_in.data;
      end else if (msg_out.rdy) begin
        msg_out.valid <= 1'b0;
      end
      if (acc & ~fwd)
        dropped_words <= dw_sat;
      if (acc) begin
        if (state == IDLE) begin
          state <= (msg_in.sop & ~msg_in.eop) ? IN_PKT : IDLE;
          word_cnt <= CW'(msg_in.sop & ~msg_in.eop);
        end else if (state == IN_PKT) begin
          state <= msg_in.eop ? IDLE : trunc ? DROP : IN_PKT;
          word_cnt <= msg_in.eop ? '0 : word_cnt + CW'(1);
        end else if (msg_in.eop) begin
          state <= IDLE;
          word_cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_avalon_packet_limiter.sv
// tb_avalon_packet_limiter: directed self-checking bench for avalon_packet_limiter with MAX_WORDS=4
module tb_avalon_packet_limiter;
  logic clk = 1'b0;
  logic rst;
  logic packet_truncated;
  logic [15:0] dropped_words;
  int vectors = 0;
  int miscompares = 0;
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(8)) in_if ();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(8)) out_if ();
  avalon_packet_limiter #(.DATA_WIDTH_IN_BYTES(8), .MAX_WORDS(4)) dut (
    .clk(clk),
    .rst(rst),
    .msg_in(in_if),
    .msg_out(out_if),
    .packet_truncated(packet_truncated),
    .dropped_words(dropped_words)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic v, input logic s, input logic e, input logic [2:0] em, input logic [63:0] d);
    chk(tag, 80'({out_if.valid, out_if.sop, out_if.eop, out_if.empty, out_if.data}), 80'({v, s, e, em, d}));
  endtask
  task automatic beat(input logic v, input logic s, input logic e, input logic [2:0] em, input logic [63:0] d);
    in_if.valid = v;
    in_if.sop = s;
    in_if.eop = e;
    in_if.empty = em;
    in_if.data = d;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b0;
    out_if.rdy = 1'b1;
    beat(0, 0, 0, 0, 64'h0);
    beat(0, 0, 0, 0, 64'h0);
    chk_out("reset_out", 0, 0, 0, 0, 64'h0);
    chk("reset_pt", 80'(packet_truncated), 80'(0));
    chk("reset_dw", 80'(dropped_words), 80'(0));
    chk("reset_rdy", 80'(in_if.rdy), 80'(1));
    rst = 1'b1;
    beat(1, 1, 0, 0, 64'hA0);
    chk_out("t1_d0", 1, 1, 0, 0, 64'hA0);
    beat(1, 0, 0, 5, 64'hA1);
    chk_out("t1_d1", 1, 0, 0, 0, 64'hA1);
    beat(1, 0, 1, 1, 64'hA2);
    chk_out("t1_d2", 1, 0, 1, 1, 64'hA2);
    chk("t1_pt", 80'(packet_truncated), 80'(0));
    beat(0, 0, 0, 0, 64'h0);
    chk("t1_idle", 80'(out_if.valid), 80'(0));
    chk("t1_dw", 80'(dropped_words), 80'(0));
    beat(1, 1, 0, 0, 64'hB0);
    chk_out("t2_d0", 1, 1, 0, 0, 64'hB0);
    beat(1, 0, 0, 0, 64'hB1);
    chk_out("t2_d1", 1, 0, 0, 0, 64'hB1);
    beat(1, 0, 0, 0, 64'hB2);
    chk_out("t2_d2", 1, 0, 0, 0, 64'hB2);
    chk("t2_pt_early", 80'(packet_truncated), 80'(0));
    beat(1, 0, 0, 6, 64'hB3);
    chk_out("t2_d3_trunc", 1, 0, 1, 0, 64'hB3);
    chk("t2_pt", 80'(packet_truncated), 80'(1));
    beat(1, 0, 0, 0, 64'hB4);
    chk("t2_d4_valid", 80'(out_if.valid), 80'(0));
    chk("t2_pt_once", 80'(packet_truncated), 80'(0));
    chk("t2_dw1", 80'(dropped_words), 80'(1));
    beat(1, 1, 0, 0, 64'hB5);
    chk("t2_d5_sop_valid", 80'(out_if.valid), 80'(0));
    chk("t2_dw2", 80'(dropped_words), 80'(2));
    chk("t2_drop_rdy", 80'(in_if.rdy), 80'(1));
    beat(1, 0, 1, 2, 64'hB6);
    chk("t2_d6_valid", 80'(out_if.valid), 80'(0));
    chk("t2_dw3", 80'(dropped_words), 80'(3));
    beat(1, 1, 0, 0, 64'hC0);
    chk_out("t3_d0", 1, 1, 0, 0, 64'hC0);
    beat(1, 0, 0, 0, 64'hC1);
    chk_out("t3_d1", 1, 0, 0, 0, 64'hC1);
    beat(1, 0, 0, 0, 64'hC2);
    chk_out("t3_d2", 1, 0, 0, 0, 64'hC2);
    beat(1, 0, 1, 3, 64'hC3);
    chk_out("t3_d3", 1, 0, 1, 3, 64'hC3);
    chk("t3_pt", 80'(packet_truncated), 80'(0));
    chk("t3_dw", 80'(dropped_words), 80'(3));
    beat(1, 1, 1, 7, 64'hE0);
    chk_out("t4_single", 1, 1, 1, 7, 64'hE0);
    beat(1, 0, 0, 0, 64'hE1);
    chk("t4_nosop_valid", 80'(out_if.valid), 80'(0));
    chk("t4_dw", 80'(dropped_words), 80'(4));
    beat(1, 1, 0, 0, 64'hF0);
    chk_out("t5_d0", 1, 1, 0, 0, 64'hF0);
    in_if.sop = 1'b0;
    in_if.data = 64'hF1;
    out_if.rdy = 1'b0;
    #1;
    chk("t5_rdy_low", 80'(in_if.rdy), 80'(0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk_out("t5_hold", 1, 1, 0, 0, 64'hF0);
      chk("t5_hold_rdy", 80'(in_if.rdy), 80'(0));
    end
    out_if.rdy = 1'b1;
    #1;
    chk("t5_rdy_release", 80'(in_if.rdy), 80'(1));
    @(posedge clk);
    #1;
    chk_out("t5_d1", 1, 0, 0, 0, 64'hF1);
    beat(1, 0, 1, 4, 64'hF2);
    chk_out("t5_d2", 1, 0, 1, 4, 64'hF2);
    beat(0, 0, 0, 0, 64'h0);
    chk("t5_idle", 80'(out_if.valid), 80'(0));
    chk("t5_dw", 80'(dropped_words), 80'(4));
    beat(1, 1, 0, 0, 64'h60);
    chk_out("t6_g0", 1, 1, 0, 0, 64'h60);
    beat(1, 0, 0, 0, 64'h61);
    chk_out("t6_g1", 1, 0, 0, 0, 64'h61);
    rst = 1'b0;
    beat(0, 0, 0, 0, 64'h0);
    chk_out("t6_rst_out", 0, 0, 0, 0, 64'h0);
    chk("t6_rst_dw", 80'(dropped_words), 80'(0));
    chk("t6_rst_pt", 80'(packet_truncated), 80'(0));
    rst = 1'b1;
    beat(1, 0, 1, 0, 64'h70);
    chk("t6_nosop_valid", 80'(out_if.valid), 80'(0));
    chk("t6_nosop_dw", 80'(dropped_words), 80'(1));
    beat(1, 1, 1, 1, 64'h71);
    chk_out("t6_new_pkt", 1, 1, 1, 1, 64'h71);
    for (int i = 0; i < 65534; i++)
      beat(1, 0, 0, 0, 64'h80);
    chk("t7_dw_max", 80'(dropped_words), 80'(16'hFFFF));
    beat(1, 0, 0, 0, 64'h81);
    chk("t7_dw_sat", 80'(dropped_words), 80'(16'hFFFF));
    beat(0, 0, 0, 0, 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/avalon_packet_limiter.md
# avalon_packet_limiter

Downstream stage of the packet enforcer. It consumes the enforced Avalon-ST stream and bounds every packet to MAX_WORDS beats. Oversized packets are truncated: a forced eop is placed on beat MAX_WORDS and the tail is discarded up to the original eop. The output is registered for timing, adding one cycle of latency, and the block reports truncations and discarded beats to the status logic.

## Interface
- DATA_WIDTH_IN_BYTES, 8: width of the data bus in bytes; data is 8*DATA_WIDTH_IN_BYTES bits, empty is $clog2(DATA_WIDTH_IN_BYTES) bits.
- MAX_WORDS, 64: maximum beats per output packet; legal range 2..65535.
- clk  input  1  the single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-low reset, sampled on posedge clk.
- msg_in  avalon_st_if.slave  bundle  enforced input stream (valid, rdy, sop, eop, empty, data).
- msg_out  avalon_st_if.master  bundle  bounded output stream (same signals).
- packet_truncated  output  1  one-cycle pulse when a truncating beat is accepted.
- dropped_words  output  16  saturating count of discarded input beats since reset.

## Operation
- Accept on input: msg_in.valid & msg_in.rdy. Accept on output: msg_out.valid & msg_out.rdy.
- Output register (out_reg) holds valid/sop/eop/empty/data and drives msg_out directly.
- msg_in.rdy:
  - In FORWARD-capable states (IDLE, IN_PKT): ~out_reg.valid | msg_out.rdy.
  - In DROP: constant 1.
- word_cnt: $clog2(MAX_WORDS+1) bits; holds the beats forwarded in the current packet.
- States:
  - IDLE: between packets.
    - Accepted beat with sop & eop: forward unchanged; stay IDLE; word_cnt=0.
    - Accepted beat with sop & ~eop: forward; word_cnt=1; go to IN_PKT.
    - Accepted beat without sop: discard (not loaded to out_reg); dropped_words+1; stay IDLE.
  - IN_PKT: inside a packet; every accepted beat is forwarded with sop forced to 0.
    - Beat with eop: forward unchanged; word_cnt=0; go to IDLE.
    - Beat with ~eop and word_cnt+1 == MAX_WORDS: forward with eop forced 1 and empty forced 0; pulse packet_truncated; go to DROP.
    - Otherwise: forward; word_cnt+1.
  - DROP: discarding the tail of an oversized packet.
    - Every accepted beat is discarded; dropped_words+1.
    - The accepted beat with eop returns the block to IDLE and word_cnt=0; that beat is also discarded and counted.
    - sop inside DROP is treated as ordinary data and discarded.
- Output empty: passed through only on beats forwarded with eop=1; otherwise 0.
- dropped_words saturates at 16'hFFFF and never wraps.
- packet_truncated is high for exactly one cycle, the cycle after the truncating accept, aligned with that beat appearing in out_reg.

## Timing
- Reset values:
  - msg_out.valid=0; sop, eop, empty, data all 0.
  - State=IDLE; word_cnt=0; packet_truncated=0; dropped_words=0.
  - msg_in.rdy=1, since out_reg is empty.
- Reset mid-packet: the partial packet is abandoned and out_reg is cleared with no eop emitted. The next beat must carry sop to be forwarded.
- Latency: an accepted beat appears on msg_out on the next cycle.
- Throughput: one beat per cycle while msg_out.rdy=1.
- Backpressure:
  - While out_reg.valid=1 and msg_out.rdy=0, out_reg is held stable with all fields unchanged.
  - In IDLE/IN_PKT this drives msg_in.rdy=0. DROP keeps consuming regardless.
- Simultaneous events: the output accept and a new input load occur in the same cycle; the new beat replaces out_reg.
- Leaving DROP on eop: the next beat can be accepted in the following cycle.
- Exactly MAX_WORDS beats with eop on the last beat: forwarded unchanged; no pulse; no drops.

## Test plan
- MAX_WORDS=4, msg_out.rdy=1. Send a 3-beat packet D0..D2, eop on D2 with empty=1.
  - Required: identical beats one cycle later, empty=1 on D2; packet_truncated=0; dropped_words=0.
- MAX_WORDS=4. Send a 7-beat packet D0..D6, eop on D6 with empty=2.
  - Required: output D0..D3 with eop=1 and empty=0 on D3; one packet_truncated pulse aligned with D3; dropped_words=3; state IDLE afterward.
- MAX_WORDS=4. Send a 4-beat packet, eop on the 4th beat.
  - Required: passed unchanged; no pulse; dropped_words=0.
- Single-beat packet (sop & eop) then a beat without sop.
  - Required: the first beat is forwarded; the second is discarded; dropped_words=1.
- Hold msg_out.rdy=0 for 5 cycles during a 3-beat packet.
  - Required: out_reg stable; msg_in.rdy=0 while out_reg.valid=1; no beat lost or duplicated after release.
- Assert rst=0 for one cycle during IN_PKT.
  - Required: next cycle msg_out.valid=0 and dropped_words=0; a new sop packet is forwarded normally.
